// File: rtl/ila_capture_ctrl_pkg.sv
// ila_capture_ctrl_pkg: default widths and FSM state encoding for the ILA capture sequencer
package ila_capture_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_HOLDOFF_WIDTH = 4;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    PRIMED  = 3'd2,
    HOLDOFF = 3'd3,
    READ    = 3'd4
  } state_t;
endpackage

// File: rtl/ila_capture_ctrl_trig_match.sv
// ila_capture_ctrl_trig_match: masked value compare with optional rising-edge qualification
module ila_capture_ctrl_trig_match
  import ila_capture_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  track,
  input  logic                  edge_mode,
  input  logic                  force_trig,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  hit
);
  logic match, match_prev;
  assign match = ((data ^ value) & mask) == '0;
  assign hit = en & ((edge_mode ? match & ~match_prev : match) | force_trig);
  // match of the previously written sample, so data held across PRIMED entry is not a rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) match_prev <= 1'b0;
    else match_prev <= track & match;
endmodule

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: ILA capture sequencer - arm, circular fill, trigger, holdoff, oldest-first readout
module ila_capture_ctrl
  import ila_capture_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int HOLDOFF_WIDTH = DEF_HOLDOFF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_arm,
  input  logic                     i_abort,
  input  logic                     i_force_trig,
  input  logic                     i_trig_edge,
  input  logic [DATA_WIDTH-1:0]    i_trig_mask,
  input  logic [DATA_WIDTH-1:0]    i_trig_value,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_we,
  output logic [ADDR_WIDTH-1:0]    o_waddr,
  output logic [ADDR_WIDTH-1:0]    o_raddr,
  input  logic [DATA_WIDTH-1:0]    i_rdata,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_last,
  output logic                     o_primed,
  output logic                     o_stopped,
  output logic [ADDR_WIDTH-1:0]    o_trig_addr,
  output logic                     o_done
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ONE = {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};
  state_t state;
  logic [ADDR_WIDTH-1:0] fill_cnt, rd_cnt, waddr_next;
  logic [HOLDOFF_WIDTH-1:0] cnt;
  logic hit, fetch, last_write;
  assign waddr_next = o_waddr + ADDR_ONE;
  assign last_write = (state == PRIMED && hit && i_holdoff == '0) || (state == HOLDOFF && cnt == HOLD_ONE);
  ila_capture_ctrl_trig_match #(.DATA_WIDTH(DATA_WIDTH)) u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state == PRIMED),
    .track      (state == FILL || state == PRIMED),
    .edge_mode  (i_trig_edge),
    .force_trig (i_force_trig),
    .mask       (i_trig_mask),
    .value      (i_trig_value),
    .data       (i_data),
    .hit        (hit)
  );
  // capture sequencer: pointers, holdoff count and readout register; fetch marks i_rdata valid for the pending address
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      o_we <= 1'b0;
      o_waddr <= '0;
      o_raddr <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_last <= 1'b0;
      o_primed <= 1'b0;
      o_stopped <= 1'b0;
      o_trig_addr <= '0;
      o_done <= 1'b0;
      fill_cnt <= '0;
      rd_cnt <= '0;
      cnt <= '0;
      fetch <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_abort) begin
        state <= IDLE;
        o_we <= 1'b0;
        o_valid <= 1'b0;
        o_last <= 1'b0;
        fetch <= 1'b0;
      end else begin
        case (state)
          IDLE: if (i_arm) begin
            state <= FILL;
            o_we <= 1'b1;
            o_waddr <= '0;
            fill_cnt <= '0;
            o_primed <= 1'b0;
            o_stopped <= 1'b0;
          end
          FILL: begin
            o_waddr <= waddr_next;
            fill_cnt <= fill_cnt + ADDR_ONE;
            if (fill_cnt == '1) begin
              state <= PRIMED;
              o_primed <= 1'b1;
            end
          end
          PRIMED: begin
            o_waddr <= waddr_next;
            if (hit) begin
              state <= HOLDOFF;
              o_trig_addr <= o_waddr;
              cnt <= i_holdoff;
            end
          end
          HOLDOFF: begin
            o_waddr <= waddr_next;
            cnt <= cnt - HOLD_ONE;
          end
          READ: if (fetch) begin
            o_data <= i_rdata;
            o_valid <= 1'b1;
            o_last <= rd_cnt == '1;
            rd_cnt <= rd_cnt + ADDR_ONE;
            o_raddr <= o_raddr + ADDR_ONE;
            fetch <= 1'b0;
          end else if (!o_valid) fetch <= 1'b1;
          else if (i_ready) begin
            o_valid <= 1'b0;
            o_last <= 1'b0;
            fetch <= ~o_last;
            if (o_last) begin
              state <= IDLE;
              o_done <= 1'b1;
              o_primed <= 1'b0;
              o_stopped <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
        // final write of the capture (overrides HOLDOFF entry when holdoff is zero): freeze and point at oldest sample
        if (last_write) begin
          state <= READ;
          o_we <= 1'b0;
          o_stopped <= 1'b1;
          o_raddr <= waddr_next;
          rd_cnt <= '0;
          fetch <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_ila_capture_ctrl.sv
// tb_ila_capture_ctrl: randomized directed bench for the ILA capture sequencer against a sample-list model
module tb_ila_capture_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_arm = 1'b0, i_abort = 1'b0, i_force_trig = 1'b0, i_trig_edge = 1'b0, i_ready = 1'b0;
  logic [7:0] i_trig_mask = '0, i_trig_value = '0, i_data = '0, i_rdata = '0;
  logic [3:0] i_holdoff = '0;
  logic o_we, o_valid, o_last, o_primed, o_stopped, o_done;
  logic [3:0] o_waddr, o_raddr, o_trig_addr;
  logic [7:0] o_data;
  logic [7:0] mem [16];
  logic [7:0] stim [80];
  int n_assert = 0;
  int n_fail = 0;
  string cur = "";

  ila_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_arm(i_arm), .i_abort(i_abort), .i_force_trig(i_force_trig),
    .i_trig_edge(i_trig_edge), .i_trig_mask(i_trig_mask), .i_trig_value(i_trig_value),
    .i_holdoff(i_holdoff), .i_data(i_data), .o_we(o_we), .o_waddr(o_waddr), .o_raddr(o_raddr),
    .i_rdata(i_rdata), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_primed(o_primed), .o_stopped(o_stopped), .o_trig_addr(o_trig_addr), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // external capture RAM with one-cycle synchronous read
  always @(posedge clk) begin
    if (o_we) mem[o_waddr] <= i_data;
    i_rdata <= mem[o_raddr];
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=0x%0h expected=0x%0h", cur, tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({o_we, o_waddr, o_raddr, o_valid, o_data, o_last, o_primed, o_stopped, o_trig_addr, o_done}), 32'd0);
  endtask

  // index (counted from arm) of the sample that becomes the trigger
  function automatic int find_trig(logic [7:0] mask, logic [7:0] value, bit edge_m, int force_cyc);
    bit m, mp;
    for (int i = 16; i < 64; i++) begin
      m = ((stim[i] ^ value) & mask) == 8'h00;
      mp = ((stim[i-1] ^ value) & mask) == 8'h00;
      if ((edge_m ? (m && !mp) : m) || i == force_cyc) return i;
    end
    return 63;
  endfunction

  task automatic run(input logic [7:0] mask, input logic [7:0] value, input bit edge_m, input logic [3:0] ho,
                     input int force_cyc, input int arm_at, input int abort_hold, input int rst_fill,
                     input int abort_word, input int rst_word, input bit rnd_ready);
    int t, n, w, guard;
    bit stall;
    logic [7:0] held;
    t = find_trig(mask, value, edge_m, force_cyc);
    n = t + int'(ho) + 1;
    i_trig_mask = mask;
    i_trig_value = value;
    i_trig_edge = edge_m;
    i_holdoff = ho;
    i_ready = 1'b0;
    i_arm = 1'b1;
    cyc;
    for (int i = 0; i < n; i++) begin
      i_data = stim[i];
      i_force_trig = (i == force_cyc);
      i_arm = (i == arm_at);
      if (i == abort_hold) begin
        i_abort = 1'b1;
        cyc;
        i_abort = 1'b0;
        i_force_trig = 1'b0;
        chk("abort_we", 32'(o_we), 32'd0);
        chk("abort_valid", 32'(o_valid), 32'd0);
        repeat (3) begin
          cyc;
          chk("abort_idle_we", 32'(o_we), 32'd0);
          chk("abort_no_done", 32'(o_done), 32'd0);
        end
        return;
      end
      if (i == rst_fill) begin
        rst_n = 1'b0;
        #1;
        chk_zero("rst_fill_outs");
        cyc;
        rst_n = 1'b1;
        i_force_trig = 1'b0;
        cyc;
        chk_zero("rst_fill_idle");
        return;
      end
      chk("we", 32'(o_we), 32'd1);
      chk("waddr", 32'(o_waddr), 32'(i % 16));
      chk("primed", 32'(o_primed), 32'(i >= 16));
      chk("stopped", 32'(o_stopped), 32'd0);
      cyc;
    end
    i_force_trig = 1'b0;
    i_arm = 1'b0;
    chk("frozen_we", 32'(o_we), 32'd0);
    chk("frozen_stopped", 32'(o_stopped), 32'd1);
    chk("trig_addr", 32'(o_trig_addr), 32'(t % 16));
    w = 0;
    guard = 0;
    stall = 1'b0;
    held = '0;
    while (w < 16 && guard < 300) begin
      i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w == abort_word && o_valid) begin
        i_abort = 1'b1;
        i_ready = 1'b0;
        cyc;
        i_abort = 1'b0;
        chk("rd_abort_valid", 32'(o_valid), 32'd0);
        chk("rd_abort_we", 32'(o_we), 32'd0);
        repeat (3) begin
          cyc;
          chk("rd_abort_no_done", 32'(o_done), 32'd0);
          chk("rd_abort_idle", 32'(o_valid), 32'd0);
        end
        return;
      end
      if (w == rst_word && o_valid) begin
        rst_n = 1'b0;
        #1;
        chk_zero("rst_read_outs");
        cyc;
        rst_n = 1'b1;
        cyc;
        chk_zero("rst_read_idle");
        return;
      end
      if (stall) begin
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_data", 32'(o_data), 32'(held));
      end
      if (o_valid && i_ready) begin
        chk("word", 32'(o_data), 32'(stim[n-16+w]));
        chk("last", 32'(o_last), 32'(w == 15));
        w++;
        stall = 1'b0;
      end else begin
        stall = o_valid;
        held = o_data;
      end
      cyc;
      guard++;
    end
    i_ready = 1'b0;
    chk("words", 32'(w), 32'd16);
    if (!rnd_ready) chk("cycles", 32'(guard), 32'd33);
    chk("done", 32'(o_done), 32'd1);
    chk("end_valid", 32'(o_valid), 32'd0);
    chk("end_stopped", 32'(o_stopped), 32'd0);
    chk("end_primed", 32'(o_primed), 32'd0);
    cyc;
    chk("done_pulse", 32'(o_done), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cur = "reset";
    chk_zero("outs");
    rst_n = 1'b1;
    cyc;
    chk("idle_we", 32'(o_we), 32'd0);

    cur = "counter_level";
    for (int i = 0; i < 80; i++) stim[i] = 8'(i);
    run(8'hFF, 8'h20, 1'b0, 4'd3, -1, -1, -1, -1, -1, -1, 1'b0);

    cur = "edge";
    for (int i = 0; i < 80; i++) stim[i] = (i < 17) ? 8'h20 : 8'($urandom);
    stim[17] = 8'h00;
    stim[18] = 8'h20;
    run(8'hFF, 8'h20, 1'b1, 4'd2, -1, -1, -1, -1, -1, -1, 1'b1);

    cur = "force_ho0";
    for (int i = 0; i < 80; i++) stim[i] = 8'h55 ^ 8'(i);
    stim[16] = 8'h3C;
    run(8'hFF, 8'hAA, 1'b0, 4'd0, 16, -1, -1, -1, -1, -1, 1'b0);

    cur = "random_mask";
    for (int i = 0; i < 80; i++) stim[i] = 8'($urandom);
    stim[30] = {stim[30][7:4], 4'h5};
    run(8'h0F, 8'h05, 1'b0, 4'd7, -1, -1, -1, -1, -1, -1, 1'b1);

    cur = "mask0_ho15";
    for (int i = 0; i < 80; i++) stim[i] = 8'($urandom);
    run(8'h00, 8'h00, 1'b0, 4'd15, -1, -1, -1, -1, -1, -1, 1'b1);

    cur = "abort_holdoff";
    for (int i = 0; i < 80; i++) stim[i] = 8'(i);
    run(8'hFF, 8'h12, 1'b0, 4'd5, -1, -1, 20, -1, -1, -1, 1'b0);

    cur = "abort_read";
    run(8'hFF, 8'h13, 1'b0, 4'd1, -1, -1, -1, -1, 5, -1, 1'b1);

    cur = "reset_fill";
    run(8'hFF, 8'h13, 1'b0, 4'd1, -1, -1, -1, 5, -1, -1, 1'b0);

    cur = "reset_read";
    run(8'hFF, 8'h18, 1'b0, 4'd2, -1, -1, -1, -1, -1, 3, 1'b0);

    cur = "arm_in_primed";
    run(8'hFF, 8'h1A, 1'b0, 4'd4, -1, 18, -1, -1, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
